// File: rtl/phy_rx_lanes.sv
// phy_rx_lanes: multi-lane comma-aligned serial receiver with per-lane skew FIFOs and round-robin word assembly.
// Define PHY_RX_RESYNC_EN to drop a lane back to hunting after RESYNC_BYTES byte periods without a comma.
module phy_rx_lanes #(
  parameter int         LANES        = 2,
  parameter int         WORD_BYTES   = 4,
  parameter logic [7:0] COMMA        = 8'hBC,
  parameter int         SYNC_COMMAS  = 4,
  parameter int         RESYNC_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        data_in_lane,
  output logic [8*WORD_BYTES-1:0] data_out,
  output logic                    valid_out,
  output logic                    active_out,
  output logic                    err_out
);
  localparam int GROUPS = WORD_BYTES / LANES;
  localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam int CW = $clog2(SYNC_COMMAS + 1);
  typedef enum logic {INIT, SYNC} state_t;

  if (LANES < 1 || WORD_BYTES % LANES != 0 || SYNC_COMMAS < 1 || RESYNC_BYTES < 1) begin : g_bad_cfg
    $error("phy_rx_lanes: invalid parameter combination");
  end

  logic [LANES-1:0]        w_sync;
  logic [LANES-1:0]        w_nempty;
  logic [LANES-1:0]        w_ovf;
  logic [7:0]              w_head [LANES];
  logic                    w_run;
  logic                    w_pop;
  logic [GW-1:0]           r_grp;
  logic [8*WORD_BYTES-1:0] r_part;
  logic [8*WORD_BYTES-1:0] w_word;

  // FIFOs only run while the link is up and every lane still holds sync.
  assign w_run = active_out & (&w_sync);
  assign w_pop = w_run & (&w_nempty);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    state_t        r_state;
    state_t        w_state;
    logic [7:0]    r_sr;
    logic [7:0]    w_sr;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit;
    logic [CW-1:0] r_cc;
    logic [CW-1:0] w_cc;
    logic          r_wv;
    logic          w_wv;
    logic [7:0]    r_wb;
    logic [7:0]    r_mem [4];
    logic [1:0]    r_rp;
    logic [1:0]    r_wp;
    logic [2:0]    r_fc;
    logic          w_bnd;
    logic          w_comma;
    logic          w_we;
    logic          w_wr;
    logic          w_full;
`ifdef PHY_RX_RESYNC_EN
    localparam int TW = $clog2(RESYNC_BYTES + 1);
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo;
`endif

    assign w_sr = {r_sr[6:0], data_in_lane[l]};
    assign w_comma = w_sr == COMMA;
    assign w_bnd = r_bit == 3'd7;
    assign w_full = r_fc[2];
    assign w_we = r_wv & w_run;
    assign w_wr = w_we & (~w_full | w_pop);
    assign w_ovf[l] = w_we & w_full & ~w_pop;
    assign w_nempty[l] = r_fc != 3'd0;
    assign w_head[l] = r_mem[r_rp];
    assign w_sync[l] = r_state == SYNC;

    always_comb begin
      w_state = r_state;
      w_bit = r_bit + 3'd1;
      w_cc = r_cc;
      w_wv = 1'b0;
`ifdef PHY_RX_RESYNC_EN
      w_tmo = '0;
`endif
      if (r_state == INIT) begin
        if (r_cc == '0 && w_comma) begin
          w_bit = 3'd0;
          w_cc = CW'(1);
        end else if (r_cc != '0 && w_bnd)
          w_cc = w_comma ? r_cc + CW'(1) : '0;
        if (w_cc == CW'(SYNC_COMMAS))
          w_state = SYNC;
      end else begin
        w_cc = '0;
        w_wv = w_bnd & ~w_comma;
`ifdef PHY_RX_RESYNC_EN
        w_tmo = w_bnd ? (w_comma ? '0 : r_tmo + TW'(1)) : r_tmo;
        if (w_tmo == TW'(RESYNC_BYTES)) begin
          w_state = INIT;
          w_wv = 1'b0;
        end
`endif
      end
    end

    always_ff @(posedge clk or posedge reset)
      if (reset)
        r_state <= INIT;
      else
        r_state <= w_state;

    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_sr <= '0;
        r_bit <= '0;
        r_cc <= '0;
        r_wv <= 1'b0;
        r_wb <= '0;
        r_rp <= '0;
        r_wp <= '0;
        r_fc <= '0;
`ifdef PHY_RX_RESYNC_EN
        r_tmo <= '0;
`endif
      end else begin
        r_sr <= w_sr;
        r_bit <= w_bit;
        r_cc <= w_cc;
        r_wv <= w_wv;
        r_wb <= w_sr;
`ifdef PHY_RX_RESYNC_EN
        r_tmo <= w_tmo;
`endif
        if (!w_run) begin
          r_rp <= '0;
          r_wp <= '0;
          r_fc <= '0;
        end else begin
          if (w_wr)
            r_wp <= r_wp + 2'd1;
          if (w_pop)
            r_rp <= r_rp + 2'd1;
          r_fc <= r_fc + {2'b0, w_wr} - {2'b0, w_pop};
        end
      end

    always_ff @(posedge clk)
      if (w_wr)
        r_mem[r_wp] <= r_wb;
  end

  always_comb begin
    w_word = r_part;
    for (int k = 0; k < LANES; k++)
      w_word[8*(WORD_BYTES-1-(int'(r_grp)*LANES+k)) +: 8] = w_head[k];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_out <= '0;
      valid_out <= 1'b0;
      active_out <= 1'b0;
      err_out <= 1'b0;
      r_grp <= '0;
      r_part <= '0;
    end else begin
      valid_out <= 1'b0;
      active_out <= &w_sync;
      if (|w_ovf)
        err_out <= 1'b1;
      if (!w_run) begin
        r_grp <= '0;
        r_part <= '0;
      end else if (w_pop) begin
        r_part <= w_word;
        if (r_grp == GW'(GROUPS-1)) begin
          r_grp <= '0;
          data_out <= w_word;
          valid_out <= 1'b1;
        end else
          r_grp <= r_grp + GW'(1);
      end
    end
endmodule

// File: tb/tb_phy_rx_lanes.sv
// tb_phy_rx_lanes: table-driven checks of 2-lane and 4-lane phy_rx_lanes builds plus reset and resync sequences.
`timescale 1ns/1ps
module tb_phy_rx_lanes;
  typedef struct packed {
    logic                  wide;
    logic [3:0][4:0]       pre;
    logic [3:0][23:0][7:0] b;
    logic [63:0]           exp_word;
    logic [3:0]            exp_valid;
    logic                  exp_err;
    logic                  exp_active;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  din = '0;
  logic [31:0] data2;
  logic        valid2, active2, err2;
  logic [63:0] data4;
  logic        valid4, active4, err4;
  logic [7:0]  bc = 8'hBC;
  int          checks = 0;
  int          fails = 0;
  int          nvalid = 0;
  vec_t        tv [5];
  vec_t        cur;

  always #5 clk = ~clk;

  phy_rx_lanes #(.LANES(2), .WORD_BYTES(4), .RESYNC_BYTES(8)) dut2 (
    .clk(clk), .reset(reset), .data_in_lane(din[1:0]),
    .data_out(data2), .valid_out(valid2), .active_out(active2), .err_out(err2));

  phy_rx_lanes #(.LANES(4), .WORD_BYTES(8), .RESYNC_BYTES(8)) dut4 (
    .clk(clk), .reset(reset), .data_in_lane(din),
    .data_out(data4), .valid_out(valid4), .active_out(active4), .err_out(err4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    din = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Bit t of each lane stream; after the table bytes the line idles on aligned commas.
  task automatic run(input int t0, input int t1);
    int j;
    if (t0 == 0)
      nvalid = 0;
    for (int t = t0; t < t1; t++) begin
      @(negedge clk);
      if (cur.wide ? valid4 : valid2)
        nvalid++;
      for (int l = 0; l < 4; l++) begin
        j = t - int'(cur.pre[l]);
        din[l] = j < 0 ? 1'b0 : j < 192 ? cur.b[l][23 - j/8][7 - j%8] : bc[7 - j%8];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      tv[i] = '0;
      tv[i].b[2] = {24{8'hBC}};
      tv[i].b[3] = {24{8'hBC}};
      tv[i].exp_active = 1'b1;
    end
    tv[0].b[0] = {{4{8'hBC}}, 8'h11, 8'h33, {18{8'hBC}}};
    tv[0].b[1] = {{4{8'hBC}}, 8'h22, 8'h44, {18{8'hBC}}};
    tv[0].exp_word = 64'h11223344;
    tv[0].exp_valid = 4'd1;
    tv[1].b[0] = {{6{8'hBC}}, 8'h11, 8'h33, {16{8'hBC}}};
    tv[1].b[1] = {{6{8'hBC}}, 8'h22, 8'h44, {16{8'hBC}}};
    tv[1].pre[1] = 5'd13;
    tv[1].exp_word = 64'h11223344;
    tv[1].exp_valid = 4'd1;
    tv[2].wide = 1'b1;
    tv[2].b[0] = {{4{8'hBC}}, 8'h00, 8'hBC, 8'h04, {17{8'hBC}}};
    tv[2].b[1] = {{4{8'hBC}}, 8'h01, 8'h05, {18{8'hBC}}};
    tv[2].b[2] = {{5{8'hBC}}, 8'h02, 8'h06, {17{8'hBC}}};
    tv[2].b[3] = {{4{8'hBC}}, 8'h03, 8'hBC, 8'hBC, 8'h07, {16{8'hBC}}};
    tv[2].exp_word = 64'h0001020304050607;
    tv[2].exp_valid = 4'd1;
    tv[3].b[0] = {{4{8'hBC}}, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, {15{8'hBC}}};
    tv[3].b[1] = {24{8'hBC}};
    tv[3].exp_err = 1'b1;
    tv[4].b[0] = {{4{8'hBC}}, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, {15{8'hBC}}};
    tv[4].b[1] = {{8{8'hBC}}, 8'h11, 8'h21, 8'h31, 8'h41, {12{8'hBC}}};
    tv[4].pre[0] = 5'd1;
    tv[4].exp_word = 64'h30314041;
    tv[4].exp_valid = 4'd2;

    #2 reset = 1'b1;
    #1;
    check("reset data", 64'(data2), 64'h0);
    check("reset valid", 64'(valid2), 64'h0);
    check("reset active", 64'(active2), 64'h0);
    check("reset err", 64'(err2), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cur = tv[i];
      do_reset;
      run(0, 212);
      check($sformatf("vec%0d word", i), cur.wide ? data4 : 64'(data2), cur.exp_word);
      check($sformatf("vec%0d valid count", i), 64'(nvalid), 64'(cur.exp_valid));
      check($sformatf("vec%0d err", i), 64'(cur.wide ? err4 : err2), 64'(cur.exp_err));
      check($sformatf("vec%0d active", i), 64'(cur.wide ? active4 : active2), 64'(cur.exp_active));
    end

    cur = tv[0];
    do_reset;
    run(0, 45);
    check("midword active before reset", 64'(active2), 64'h1);
    check("midword no word yet", 64'(nvalid), 64'h0);
    #2 reset = 1'b1;
    #1;
    check("midword reset data", 64'(data2), 64'h0);
    check("midword reset valid", 64'(valid2), 64'h0);
    check("midword reset active", 64'(active2), 64'h0);
    check("midword reset err", 64'(err2), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 212);
    check("midword resync word", 64'(data2), 64'h11223344);
    check("midword resync valid count", 64'(nvalid), 64'h1);

`ifdef PHY_RX_RESYNC_EN
    cur = '0;
    cur.b[0] = {{16{8'hBC}}, 8'h11, 8'h33, {6{8'hBC}}};
    cur.b[1] = {{4{8'hBC}}, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                {4{8'hBC}}, 8'h22, 8'h44, {6{8'hBC}}};
    cur.b[2] = {24{8'hBC}};
    cur.b[3] = {24{8'hBC}};
    do_reset;
    run(0, 90);
    check("resync active before timeout", 64'(active2), 64'h1);
    run(90, 100);
    check("resync active after timeout", 64'(active2), 64'h0);
    run(100, 212);
    check("resync active restored", 64'(active2), 64'h1);
    check("resync word", 64'(data2), 64'h11223344);
    check("resync valid count", 64'(nvalid), 64'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
